// File: rtl/taptempo_pkg.sv
// Shared constants and state encodings for the tap-tempo blocks (per2bpm, bpm2beat).
// A period is counted in timepulses, so one minute spans MIN_NS / TP_CYCLE of them.
package taptempo_pkg;

    localparam int CLK_PER_NS = 40;
    localparam int TP_CYCLE   = 5120;
    localparam int BPM_MAX    = 250;

    localparam longint unsigned MIN_NS = 64'd60_000_000_000;

    localparam int PER_MAX  = int'(MIN_NS / 64'(TP_CYCLE));
    localparam int PER_SIZE = $clog2(PER_MAX + 1);
    localparam int BPM_SIZE = $clog2(BPM_MAX + 1);

    localparam int BTN_PER_MAX  = PER_MAX;
    localparam int BTN_PER_SIZE = PER_SIZE;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_div.sv
// Restoring divider that produces one quotient bit per clock, MSB first.
// The most significant bit is resolved on the start edge, so done_o rises N_W clocks after start_i.
module serial_div #(
    parameter int N_W = 24,
    parameter int D_W = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           start_i,
    input  logic [N_W-1:0] dividend_i,
    input  logic [D_W-1:0] divisor_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [N_W-1:0] quot_o
);

    localparam int R_W = N_W + D_W;
    localparam int C_W = $clog2(N_W + 1);

    logic [R_W-1:0] rem_q, rem_d;
    logic [N_W-1:0] quot_q, quot_d;
    logic [D_W-1:0] div_q, div_d;
    logic [C_W-1:0] cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           load;
    logic [R_W-1:0] src_rem;
    logic [N_W-1:0] src_quot;
    logic [D_W-1:0] src_div;
    logic [C_W-1:0] bit_pos;
    logic [R_W-1:0] shifted;
    logic           fits;

    // One restoring step, fed either by the fresh operands or by the running state.
    always_comb begin
        load     = start_i && !busy_q;
        src_rem  = load ? R_W'(dividend_i) : rem_q;
        src_quot = load ? '0 : quot_q;
        src_div  = load ? divisor_i : div_q;
        bit_pos  = load ? C_W'(N_W - 1) : (cnt_q - C_W'(1));
        shifted  = R_W'(src_div) << bit_pos;
        fits     = (shifted <= src_rem);
    end

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (load || busy_q) begin
            rem_d  = fits ? (src_rem - shifted) : src_rem;
            quot_d = {src_quot[N_W-2:0], fits};
            div_d  = src_div;
            cnt_d  = bit_pos;
            busy_d = (bit_pos != '0);
            done_d = (bit_pos == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rem_q  <= '0;
            quot_q <= '0;
            div_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign quot_o = quot_q;

endmodule

// File: rtl/bpm2beat.sv
// Converts a BPM request into a beat period in timepulses and emits a beat strobe every period.
// A new period restarts the beat phase with an immediate beat when the result lands.
module bpm2beat
    import taptempo_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                tp_i,
    input  logic [BPM_SIZE-1:0] bpm_i,
    input  logic                bpm_valid_i,
    output logic [PER_SIZE-1:0] per_o,
    output logic                per_valid_o,
    output logic                beat_o,
    output logic                busy_o
);

    state_e              state_q, state_d;
    logic                dis_q, dis_d;
    logic                en_q, en_d;
    logic                per_valid_q, per_valid_d;
    logic                beat_q, beat_d;
    logic [PER_SIZE-1:0] tick_q, tick_d;
    logic [PER_SIZE-1:0] per_q, per_d;

    logic                div_start;
    logic                div_busy;
    logic                div_done;
    logic [BPM_SIZE-1:0] divisor;
    logic [PER_SIZE-1:0] div_quot;

    // Zero maps to divisor 1 so the divider never sees 0; the beat is muted instead.
    always_comb begin
        div_start = (state_q == S_IDLE) && bpm_valid_i && !div_busy;
        if (bpm_i > BPM_SIZE'(BPM_MAX)) begin
            divisor = BPM_SIZE'(BPM_MAX);
        end else if (bpm_i == '0) begin
            divisor = BPM_SIZE'(1);
        end else begin
            divisor = bpm_i;
        end
    end

    serial_div #(
        .N_W (PER_SIZE),
        .D_W (BPM_SIZE)
    ) u_div (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (div_start),
        .dividend_i (PER_SIZE'(PER_MAX)),
        .divisor_i  (divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (div_quot)
    );

    always_comb begin
        state_d     = state_q;
        dis_d       = dis_q;
        en_d        = en_q;
        tick_d      = tick_q;
        per_d       = per_q;
        per_valid_d = 1'b0;
        beat_d      = 1'b0;

        // beat_o is registered, so it follows the terminal tp_i by one clock.
        if (en_q && tp_i) begin
            if (tick_q == per_q - PER_SIZE'(1)) begin
                beat_d = 1'b1;
                tick_d = '0;
            end else begin
                tick_d = tick_q + PER_SIZE'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (div_start) begin
                    dis_d   = (bpm_i == '0);
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    per_d       = div_quot;
                    per_valid_d = 1'b1;
                    en_d        = !dis_q;
                    tick_d      = '0;
                    beat_d      = !dis_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                tick_d  = '0;
                beat_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            dis_q       <= 1'b0;
            en_q        <= 1'b0;
            tick_q      <= '0;
            per_q       <= '0;
            per_valid_q <= 1'b0;
            beat_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dis_q       <= dis_d;
            en_q        <= en_d;
            tick_q      <= tick_d;
            per_q       <= per_d;
            per_valid_q <= per_valid_d;
            beat_q      <= beat_d;
        end
    end

    assign per_o       = per_q;
    assign per_valid_o = per_valid_q;
    assign beat_o      = beat_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bpm2beat.sv
// Directed bench for bpm2beat: expected periods go into a scoreboard when a request is issued
// and are checked when per_valid_o fires; timing and beat spacing are checked against cycle counts.
module tb_bpm2beat;
    import taptempo_pkg::*;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                tp_i;
    logic [BPM_SIZE-1:0] bpm_i;
    logic                bpm_valid_i;
    logic [PER_SIZE-1:0] per_o;
    logic                per_valid_o;
    logic                beat_o;
    logic                busy_o;

    int                  test_count = 0;
    int                  fail_count = 0;
    longint              cyc = 0;
    int                  beat_count = 0;
    int                  pv_count = 0;
    longint              req_cyc = 0;
    longint              done_cyc = 0;
    logic [PER_SIZE-1:0] sb_q[$];

    bpm2beat dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .tp_i        (tp_i),
        .bpm_i       (bpm_i),
        .bpm_valid_i (bpm_valid_i),
        .per_o       (per_o),
        .per_valid_o (per_valid_o),
        .beat_o      (beat_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (beat_o === 1'b1) beat_count <= beat_count + 1;
        if (per_valid_o === 1'b1) pv_count <= pv_count + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        test_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int bpm, input bit expect_result, input int expected_per);
        bpm_i       = bpm[BPM_SIZE-1:0];
        bpm_valid_i = 1'b1;
        req_cyc     = cyc;
        if (expect_result) sb_q.push_back(expected_per[PER_SIZE-1:0]);
        tick();
        bpm_valid_i = 1'b0;
        bpm_i       = 8'd37;
        checkOutput("busy_first_div_cycle", 64'(busy_o), 64'(1));
    endtask

    task automatic waitResult(input bit beat_exp);
        int                  k;
        logic [PER_SIZE-1:0] exp_per;
        k = 0;
        while (per_valid_o !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        checkOutput("per_valid_seen", 64'(per_valid_o), 64'(1));
        if (per_valid_o === 1'b1) begin
            done_cyc = cyc;
            checkOutput("per_valid_latency", 64'(cyc - req_cyc), 64'(25));
            checkOutput("sb_pending", 64'(sb_q.size()), 64'(1));
            if (sb_q.size() > 0) begin
                exp_per = sb_q.pop_front();
                checkOutput("per_o", 64'(per_o), 64'(exp_per));
            end
            checkOutput("beat_realign", 64'(beat_o), 64'(beat_exp));
            checkOutput("busy_in_done", 64'(busy_o), 64'(1));
        end
        tick();
        checkOutput("busy_after_done", 64'(busy_o), 64'(0));
        checkOutput("per_valid_single", 64'(per_valid_o), 64'(0));
    endtask

    initial begin
        int bpm_tab[4] = '{250, 255, 1, 60};
        int per_tab[4] = '{46875, 46875, 11718750, 195312};
        int beat_snap;
        int pv_snap;
        int k;

        // Reset state
        rst_ni      = 1'b0;
        tp_i        = 1'b0;
        bpm_i       = '0;
        bpm_valid_i = 1'b0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        checkOutput("rst_per_o", 64'(per_o), 64'(0));
        checkOutput("rst_per_valid", 64'(per_valid_o), 64'(0));
        checkOutput("rst_beat", 64'(beat_o), 64'(0));
        checkOutput("rst_busy", 64'(busy_o), 64'(0));

        // 120 BPM
        applyStimulus(120, 1'b1, 97656);
        waitResult(1'b1);

        // Top of range, clamp, bottom of range, 60 BPM
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bpm_tab[i], 1'b1, per_tab[i]);
            waitResult(1'b1);
        end

        // Second request during division is dropped
        applyStimulus(100, 1'b1, 117187);
        repeat (4) tick();
        bpm_i       = 8'd200;
        bpm_valid_i = 1'b1;
        tick();
        bpm_valid_i = 1'b0;
        bpm_i       = 8'd37;
        pv_snap     = pv_count;
        waitResult(1'b1);
        repeat (40) tick();
        checkOutput("ignored_req_no_result", 64'(pv_count - pv_snap), 64'(1));

        // Zero BPM mutes the beat
        applyStimulus(0, 1'b1, 11718750);
        waitResult(1'b0);
        tp_i      = 1'b1;
        beat_snap = beat_count;
        repeat (3000) tick();
        checkOutput("disabled_no_beats", 64'(beat_count - beat_snap), 64'(0));

        // Running at 250, then 240 loaded mid-period
        applyStimulus(250, 1'b1, 46875);
        waitResult(1'b1);
        repeat (1000) tick();
        beat_snap = beat_count;
        applyStimulus(240, 1'b1, 48828);
        waitResult(1'b1);
        checkOutput("only_realign_beat", 64'(beat_count - beat_snap), 64'(1));
        k = 0;
        while (beat_o !== 1'b1 && k < 50000) begin
            tick();
            k++;
        end
        checkOutput("next_beat_seen", 64'(beat_o), 64'(1));
        // tp_i is high every clock: the S_DONE pulse is not counted, 48828 counted pulses
        // follow it, and the registered beat lands one clock after the last of them.
        checkOutput("beat_spacing", 64'(cyc - done_cyc), 64'(48829));

        // Reset in the middle of a division
        applyStimulus(120, 1'b0, 0);
        repeat (9) tick();
        rst_ni = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 64'(busy_o), 64'(0));
        tick();
        tick();
        rst_ni    = 1'b1;
        beat_snap = beat_count;
        pv_snap   = pv_count;
        repeat (300) tick();
        checkOutput("rst_mid_per_o", 64'(per_o), 64'(0));
        checkOutput("rst_mid_per_valid", 64'(per_valid_o), 64'(0));
        checkOutput("rst_mid_beat", 64'(beat_o), 64'(0));
        checkOutput("rst_mid_busy_after", 64'(busy_o), 64'(0));
        checkOutput("rst_mid_no_beats", 64'(beat_count - beat_snap), 64'(0));
        checkOutput("rst_mid_no_result", 64'(pv_count - pv_snap), 64'(0));

        checkOutput("sb_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
